// File: rtl/alu_pkg.sv
// Shared encodings for the nibble-serial ALU and the control FSM that drives it.
// Function codes 101-111 are reserved and pass operand A through.
package alu_pkg;

  typedef enum logic [2:0] {
    FUNC_MOVE = 3'b000,
    FUNC_ADD  = 3'b001,
    FUNC_SUB  = 3'b010,
    FUNC_AND  = 3'b011,
    FUNC_OR   = 3'b100
  } func_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int NIBBLE_BITS = 4;

endpackage

// File: rtl/nibble_adder.sv
// 4-bit ripple adder with carry in/out, shared by every nibble of an ALU operation.
module nibble_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/alu_exec.sv
// Nibble-serial ALU: latches a request, processes one 4-bit slice per cycle LSB first,
// and publishes result and flags together with a one-cycle alu_end pulse.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [2:0]       alu_func,
  input  logic             alu_in_sel,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_end,
  output logic             busy,
  output logic             carry,
  output logic             zero
);

  localparam int NIB = WIDTH / NIBBLE_BITS;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [WIDTH-1:0] NIB_MASK = WIDTH'(4'hF);

  state_e           state_q;
  logic [WIDTH-1:0] opA_q, opB_q, acc_q, aluOut_q;
  logic [2:0]       func_q;
  logic [CW-1:0]    cnt_q;
  logic             chain_q, carry_q, zero_q, end_q, busy_q;

  logic [3:0]       nibA, nibB, addB, sum, nibRes;
  logic             cin, cout, isArith, isLast, accept;
  logic [WIDTH-1:0] accNext;

  assign nibA    = 4'(opA_q >> {cnt_q, 2'b00});
  assign nibB    = 4'(opB_q >> {cnt_q, 2'b00});
  assign isArith = (func_q == FUNC_ADD) || (func_q == FUNC_SUB);
  assign isLast  = (cnt_q == CW'(NIB - 1));
  assign accept  = alu_start && (state_q == IDLE || state_q == DONE);

  // Subtraction is A + ~B + 1: invert B and seed the chain with 1 on nibble 0.
  assign addB = (func_q == FUNC_SUB) ? ~nibB : nibB;
  assign cin  = (cnt_q == '0) ? (func_q == FUNC_SUB) : chain_q;

  nibble_adder uAdder (
    .a_i    (nibA),
    .b_i    (addB),
    .cin_i  (cin),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_comb begin
    nibRes = nibA;
    case (func_q)
      FUNC_MOVE: nibRes = nibB;
      FUNC_ADD,
      FUNC_SUB:  nibRes = sum;
      FUNC_AND:  nibRes = nibA & nibB;
      FUNC_OR:   nibRes = nibA | nibB;
      default:   nibRes = nibA;
    endcase
  end

  assign accNext = (acc_q & ~(NIB_MASK << {cnt_q, 2'b00}))
                 | (WIDTH'(nibRes) << {cnt_q, 2'b00});

  // Visible outputs only change on the final nibble, so they hold between completions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      func_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      chain_q  <= 1'b0;
      aluOut_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      end_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      end_q <= 1'b0;
      if (accept) begin
        opA_q   <= reg_a;
        opB_q   <= alu_in_sel ? imm : reg_b;
        func_q  <= alu_func;
        cnt_q   <= '0;
        state_q <= CALC;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          CALC: begin
            acc_q   <= accNext;
            chain_q <= cout;
            cnt_q   <= cnt_q + 1'b1;
            if (isLast) begin
              aluOut_q <= accNext;
              carry_q  <= isArith ? cout : 1'b0;
              zero_q   <= (accNext == '0);
              end_q    <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign alu_out = aluOut_q;
  assign alu_end = end_q;
  assign busy    = busy_q;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed-vector bench for alu_exec at WIDTH=8 with hand-computed expectations.
module tb_alu_exec;

  logic       clk;
  logic       rst;
  logic       alu_start;
  logic [2:0] alu_func;
  logic       alu_in_sel;
  logic [7:0] reg_a, reg_b, imm;
  logic [7:0] alu_out;
  logic       alu_end, busy, carry, zero;

  int compared   = 0;
  int mismatched = 0;

  alu_exec #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_start  (alu_start),
    .alu_func   (alu_func),
    .alu_in_sel (alu_in_sel),
    .reg_a      (reg_a),
    .reg_b      (reg_b),
    .imm        (imm),
    .alu_out    (alu_out),
    .alu_end    (alu_end),
    .busy       (busy),
    .carry      (carry),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issues one request, scrambles the inputs right after acceptance, and waits for alu_end.
  task automatic applyStimulus(input logic [2:0] f, input logic s, input logic [7:0] a,
                               input logic [7:0] b, input logic [7:0] im, output int cyc);
    alu_func = f; alu_in_sel = s; reg_a = a; reg_b = b; imm = im; alu_start = 1'b1;
    @(posedge clk); #1;
    alu_start = 1'b0;
    alu_func = ~f; alu_in_sel = ~s; reg_a = ~a; reg_b = ~b; imm = ~im;
    cyc = 0;
    while (alu_end !== 1'b1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; alu_start = 1'b1; alu_func = 3'b001; alu_in_sel = 1'b0;
    reg_a = 8'h11; reg_b = 8'h22; imm = 8'h33;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (alu_out !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_out: got %h expected 00", alu_out); end
    compared++; if (alu_end !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_end: got %b expected 0", alu_end); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (carry !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_carry: got %b expected 0", carry); end
    compared++; if (zero !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_zero: got %b expected 0", zero); end
    alu_start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int cyc;
    applyStimulus(3'b001, 1'b0, 8'h3C, 8'h0F, 8'hEE, cyc);
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL add_latency: got %0d expected 2", cyc); end
    compared++; if (alu_out !== 8'h4B) begin mismatched++; $display("[TB] FAIL add_out: got %h expected 4b", alu_out); end
    compared++; if (carry !== 1'b0) begin mismatched++; $display("[TB] FAIL add_carry: got %b expected 0", carry); end
    compared++; if (zero !== 1'b0) begin mismatched++; $display("[TB] FAIL add_zero: got %b expected 0", zero); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL add_busy_done: got %b expected 1", busy); end
    @(posedge clk); #1;
    compared++; if (alu_end !== 1'b0) begin mismatched++; $display("[TB] FAIL add_end_width: got %b expected 0", alu_end); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL add_busy_idle: got %b expected 0", busy); end
    compared++; if (alu_out !== 8'h4B) begin mismatched++; $display("[TB] FAIL add_hold: got %h expected 4b", alu_out); end

    applyStimulus(3'b001, 1'b0, 8'hFF, 8'h01, 8'h00, cyc);
    compared++; if (alu_out !== 8'h00) begin mismatched++; $display("[TB] FAIL add_wrap_out: got %h expected 00", alu_out); end
    compared++; if (carry !== 1'b1) begin mismatched++; $display("[TB] FAIL add_wrap_carry: got %b expected 1", carry); end
    compared++; if (zero !== 1'b1) begin mismatched++; $display("[TB] FAIL add_wrap_zero: got %b expected 1", zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    int cyc;
    applyStimulus(3'b010, 1'b1, 8'h03, 8'h00, 8'h05, cyc);
    compared++; if (alu_out !== 8'hFE) begin mismatched++; $display("[TB] FAIL sub_neg_out: got %h expected fe", alu_out); end
    compared++; if (carry !== 1'b0) begin mismatched++; $display("[TB] FAIL sub_neg_carry: got %b expected 0", carry); end
    compared++; if (zero !== 1'b0) begin mismatched++; $display("[TB] FAIL sub_neg_zero: got %b expected 0", zero); end
    @(posedge clk); #1;
    applyStimulus(3'b010, 1'b1, 8'h05, 8'h77, 8'h05, cyc);
    compared++; if (alu_out !== 8'h00) begin mismatched++; $display("[TB] FAIL sub_eq_out: got %h expected 00", alu_out); end
    compared++; if (carry !== 1'b1) begin mismatched++; $display("[TB] FAIL sub_eq_carry: got %b expected 1", carry); end
    compared++; if (zero !== 1'b1) begin mismatched++; $display("[TB] FAIL sub_eq_zero: got %b expected 1", zero); end
    @(posedge clk); #1;
  endtask

  task automatic test_logic;
    int cyc;
    applyStimulus(3'b000, 1'b1, 8'h12, 8'h11, 8'hA5, cyc);
    compared++; if (alu_out !== 8'hA5) begin mismatched++; $display("[TB] FAIL move_out: got %h expected a5", alu_out); end
    compared++; if (carry !== 1'b0) begin mismatched++; $display("[TB] FAIL move_carry: got %b expected 0", carry); end
    @(posedge clk); #1;
    applyStimulus(3'b011, 1'b0, 8'hF0, 8'h3C, 8'h00, cyc);
    compared++; if (alu_out !== 8'h30) begin mismatched++; $display("[TB] FAIL and_out: got %h expected 30", alu_out); end
    @(posedge clk); #1;
    applyStimulus(3'b100, 1'b0, 8'hF0, 8'h3C, 8'h00, cyc);
    compared++; if (alu_out !== 8'hFC) begin mismatched++; $display("[TB] FAIL or_out: got %h expected fc", alu_out); end
    @(posedge clk); #1;
    applyStimulus(3'b111, 1'b0, 8'h5A, 8'hC3, 8'h0F, cyc);
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL f111_latency: got %0d expected 2", cyc); end
    compared++; if (alu_out !== 8'h5A) begin mismatched++; $display("[TB] FAIL f111_out: got %h expected 5a", alu_out); end
    @(posedge clk); #1;
    applyStimulus(3'b101, 1'b0, 8'h00, 8'hC3, 8'h0F, cyc);
    compared++; if (alu_out !== 8'h00) begin mismatched++; $display("[TB] FAIL f101_out: got %h expected 00", alu_out); end
    compared++; if (zero !== 1'b1) begin mismatched++; $display("[TB] FAIL f101_zero: got %b expected 1", zero); end
    @(posedge clk); #1;
  endtask

  // alu_start held for 9 edges; operand A at edge k is k+1, func is ADD only on accepting edges.
  task automatic test_back_to_back;
    logic [7:0] expOut;
    alu_start = 1'b1; alu_in_sel = 1'b0; reg_b = 8'h01; reg_a = 8'h01; alu_func = 3'b001;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      compared++; if (alu_end !== (k % 3 == 2)) begin mismatched++; $display("[TB] FAIL b2b_end[%0d]: got %b expected %b", k, alu_end, (k % 3 == 2)); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_busy[%0d]: got %b expected 1", k, busy); end
      if (k >= 2) begin
        expOut = (k < 5) ? 8'h02 : (k < 8) ? 8'h05 : 8'h08;
        compared++; if (alu_out !== expOut) begin mismatched++; $display("[TB] FAIL b2b_out[%0d]: got %h expected %h", k, alu_out, expOut); end
      end
      reg_a = 8'(k + 2);
      alu_func = ((k + 1) % 3 == 0) ? 3'b001 : 3'b011;
    end
    alu_start = 1'b0;
    @(posedge clk); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_busy: got %b expected 0", busy); end
    compared++; if (alu_end !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_end: got %b expected 0", alu_end); end
  endtask

  task automatic test_reset_abort;
    int cyc;
    int pulses;
    alu_func = 3'b001; alu_in_sel = 1'b0; reg_a = 8'h3C; reg_b = 8'h0F; alu_start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; alu_start = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    compared++; if (alu_out !== 8'h00) begin mismatched++; $display("[TB] FAIL abort_out: got %h expected 00", alu_out); end
    compared++; if (alu_end !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_end: got %b expected 0", alu_end); end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (alu_end === 1'b1 || busy === 1'b1) pulses++;
    end
    compared++; if (pulses !== 0) begin mismatched++; $display("[TB] FAIL abort_quiet: got %0d activity cycles expected 0", pulses); end
    applyStimulus(3'b001, 1'b0, 8'h3C, 8'h0F, 8'h00, cyc);
    compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL abort_next_latency: got %0d expected 2", cyc); end
    compared++; if (alu_out !== 8'h4B) begin mismatched++; $display("[TB] FAIL abort_next_out: got %h expected 4b", alu_out); end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; alu_start = 1'b0; alu_func = 3'b000; alu_in_sel = 1'b0;
    reg_a = 8'h00; reg_b = 8'h00; imm = 8'h00;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be a multiple of 4.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 alu_start  input  1  one-cycle request from the control FSM to execute one operation.
REQ-005 alu_func  input  3  operation select; sampled only when a request is accepted.
REQ-006 alu_in_sel  input  1  operand-B source: 0 = reg_b, 1 = imm.
REQ-007 reg_a  input  WIDTH  operand A.
REQ-008 reg_b  input  WIDTH  register operand B.
REQ-009 imm  input  WIDTH  immediate operand B.
REQ-010 alu_out  output  WIDTH  registered result; holds its value until the next completion.
REQ-011 alu_end  output  1  one-cycle completion pulse to the control FSM.
REQ-012 busy  output  1  high while in CALC or DONE.
REQ-013 carry  output  1  registered carry/no-borrow flag.
REQ-014 zero  output  1  registered flag, high when alu_out == 0.

Function
REQ-015 The block SHALL use a 3-state FSM: IDLE, CALC, DONE.
REQ-016 IDLE: alu_start=1 SHALL latch reg_a, the alu_in_sel-selected operand B and alu_func, clear nibble counter, and go to CALC; otherwise stay.
REQ-017 CALC: each cycle SHALL process one 4-bit nibble, LSB first, counter index 0..WIDTH/4-1, storing the nibble and carry at the edge.
REQ-018 On the edge processing the last nibble, the FSM SHALL enter DONE with alu_out, carry and zero already final.
REQ-019 DONE: alu_end SHALL be 1 for exactly this one cycle; next state CALC if alu_start=1 (new operands latched as in IDLE), else IDLE.
REQ-020 Latency: request sampled at edge k -> alu_end high in the cycle after edge k+WIDTH/4 (k+2 for WIDTH=8); back-to-back throughput one operation per WIDTH/4+1 cycles.
REQ-021 alu_start during CALC SHALL be ignored; no queuing.
REQ-022 alu_func 000 MOVE: out=B, carry=0.
REQ-023 alu_func 001 ADD: out=A+B mod 2^WIDTH, initial carry-in 0, carry = final carry-out.
REQ-024 alu_func 010 SUB: out=A+~B+1 mod 2^WIDTH, initial carry-in 1, carry = final carry-out (1 iff A>=B unsigned).
REQ-025 alu_func 011 AND, 100 OR: bitwise, carry=0.
REQ-026 alu_func 101-111: out=A, carry=0; alu_end still pulses.
REQ-027 Changes on reg_a, reg_b, imm, alu_in_sel, alu_func after acceptance SHALL NOT affect the running operation.
REQ-028 zero SHALL be computed from the final full-width result only.

Reset
REQ-029 rst=0 at any edge SHALL force IDLE, alu_out=0, alu_end=0, busy=0, carry=0, zero=0, counter=0.
REQ-030 Reset during CALC or DONE SHALL abort the operation with no alu_end pulse, alu_out remaining 0.
REQ-031 alu_start sampled with rst=0 SHALL be discarded.

Structure
REQ-032 Package alu_pkg SHALL hold the alu_func encodings (FUNC_MOVE..FUNC_OR) and FSM state encoding, shared with the control FSM.
REQ-033 Sub-module nibble_adder (4-bit combinational adder, cin/cout) SHALL be instantiated once and reused per nibble.

Verification (WIDTH=8)
REQ-034 ADD, reg_a=0x3C, reg_b=0x0F, sel=0, start at edge 0 -> alu_end high only between edges 2 and 3, alu_out=0x4B, carry=0, zero=0.
REQ-035 ADD 0xFF+0x01 -> alu_out=0x00, carry=1, zero=1 (inter-nibble carry).
REQ-036 SUB sel=1: reg_a=0x03, imm=0x05 -> 0xFE, carry=0; reg_a=0x05, imm=0x05 -> 0x00, carry=1, zero=1.
REQ-037 AND 0xF0,0x3C -> 0x30; OR -> 0xFC; MOVE sel=1 imm=0xA5 -> 0xA5, carry=0; func 111 -> alu_out=reg_a.
REQ-038 alu_start held high 9 cycles -> start in CALC ignored, DONE re-accepts; alu_end every 3 cycles, operands changed mid-CALC not reflected.
REQ-039 rst=0 at edge 1 of an ADD -> no alu_end, alu_out=0, busy=0 from next cycle; next request completes normally.
